mac_accum: RTL

Multiply-accumulate result stage sitting directly downstream of the 32x32 unsigned multiplier. It consumes each 64-bit product `Z` over a valid/ready handshake and loads, adds or subtracts it into a 64-bit accumulator. On a LAST operation it emits the final sum with a sticky overflow flag and an operand count. It turns the single-shot multiplier into a dot-product/MAC path for the ALU.

---
 rtl/alu_pkg.sv | 19 +
 rtl/acc_addsub.sv | 25 ++
 rtl/mac_accum.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation and state encodings for the MAC result stage.
package alu_pkg;

  localparam int unsigned PROD_W = 64;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_LAST = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/acc_addsub.sv
// Combinational add/subtract of the accumulator and a product, with carry or borrow out.
module acc_addsub #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             flag
);

  logic [WIDTH:0] wide;

  // The extra top bit is the carry on add and the borrow (b > a) on subtract.
  always_comb begin
    if (sub) begin
      wide = {1'b0, a} - {1'b0, b};
    end else begin
      wide = {1'b0, a} + {1'b0, b};
    end
    res  = wide[WIDTH-1:0];
    flag = wide[WIDTH];
  end

endmodule

// File: rtl/mac_accum.sv
// MAC result stage: folds multiplier products into an accumulator and emits the
// sum, sticky overflow and product count on a LAST operation.
module mac_accum
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = PROD_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] P,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] acc;
  logic             acc_ovf;
  logic [CNT_W-1:0] acc_cnt;
  state_t           state;

  logic             accept;
  logic [WIDTH-1:0] sum;
  logic             flag;
  logic             ovf_next;
  logic [CNT_W-1:0] cnt_next;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  acc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (acc),
    .b    (P),
    .sub  (op == OP_SUB),
    .res  (sum),
    .flag (flag)
  );

  // Counter saturates at all-ones so long dot products report a pinned count, not a wrapped one.
  always_comb begin
    ovf_next = acc_ovf | flag;
    if (acc_cnt == {CNT_W{1'b1}}) begin
      cnt_next = acc_cnt;
    end else begin
      cnt_next = acc_cnt + CNT_W'(1);
    end
  end

  // Accumulator, FSM and output register; a LAST overrides the output-drain clear so results stream with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_ovf   <= 1'b0;
      acc_cnt   <= '0;
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      Z         <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        case (op)
          OP_LOAD: begin
            acc     <= P;
            acc_ovf <= 1'b0;
            acc_cnt <= CNT_W'(1);
            state   <= ST_ACCUM;
          end
          OP_ADD, OP_SUB: begin
            acc     <= sum;
            acc_ovf <= ovf_next;
            acc_cnt <= cnt_next;
            state   <= ST_ACCUM;
          end
          OP_LAST: begin
            Z         <= sum;
            ovf       <= ovf_next;
            cnt       <= cnt_next;
            out_valid <= 1'b1;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            acc_cnt   <= '0;
            state     <= ST_HOLD;
          end
          default: begin
            state <= state;
          end
        endcase
      end else if (state == ST_HOLD && out_ready) begin
        state <= ST_IDLE;
      end else begin
        state <= state;
      end
    end
  end

endmodule
